cam_frame_buffer: RTL and testbench

Camera-side responder for the CPU's camera MMIO window. It captures one decimated grayscale frame from the sensor pixel stream into an on-chip 8-bit buffer when the CPU writes the capture register. It then serves the stored pixels to the CPU sequentially, one per read of the pixel register. It sits between the camera front-end (`pix_*` stream) and the memory mux (`cam_capture_i`, `cam_read_valid_i`, `cam_pixel_o`).

---
 rtl/cam_frame_buffer_if.sv | 23 ++
 rtl/cam_frame_buffer.sv | 115 +++++++++++
 tb/tb_cam_frame_buffer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_buffer_if.sv
// CPU-side MMIO strobes and sensor pixel stream of the camera frame buffer.
interface cam_frame_buffer_if;
  localparam int unsigned PIX_W = 8;

  logic             cam_capture_i;
  logic             cam_read_valid_i;
  logic [PIX_W-1:0] cam_pixel_o;
  logic             frame_ready_o;
  logic             busy_o;
  logic             pix_frame_start_i;
  logic             pix_valid_i;
  logic [PIX_W-1:0] pix_data_i;

  modport master (
    output cam_capture_i, cam_read_valid_i, pix_frame_start_i, pix_valid_i, pix_data_i,
    input  cam_pixel_o, frame_ready_o, busy_o
  );

  modport slave (
    input  cam_capture_i, cam_read_valid_i, pix_frame_start_i, pix_valid_i, pix_data_i,
    output cam_pixel_o, frame_ready_o, busy_o
  );
endinterface

// File: rtl/cam_frame_buffer.sv
// Captures one DEC-decimated grayscale frame into an on-chip buffer and serves it sequentially.
// Optional CAM_FRAME_BUFFER_INVERT_EN stores each pixel inverted (255-p).
module cam_frame_buffer #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned DEC   = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  cam_frame_buffer_if.slave bus
);
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned SRC_W = IMG_W * DEC;
  localparam int unsigned AW    = (NPIX > 1)  ? $clog2(NPIX)  : 1;
  localparam int unsigned XW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int unsigned DW    = (DEC > 1)   ? $clog2(DEC)   : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FRAME, ST_CAPTURE, ST_READY} state_e;

  state_e        state;
  logic [XW-1:0] sx;
  logic [DW-1:0] dx, dy;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [NPIX];

  logic          capture_c, read_c, store_c, last_store_c;
  logic [AW-1:0] rd_next_c;
  logic [DW-1:0] dx_next_c, dy_next_c;
  logic [7:0]    wdata_c;

  // Pixel store path; buffer contents survive reset
`ifdef CAM_FRAME_BUFFER_INVERT_EN
  assign wdata_c = ~bus.pix_data_i;
`else
  assign wdata_c = bus.pix_data_i;
`endif

  always_comb begin
    capture_c    = bus.cam_capture_i && (state == ST_IDLE || state == ST_READY);
    read_c       = bus.cam_read_valid_i && (state == ST_READY);
    store_c      = (state == ST_CAPTURE) && !bus.pix_frame_start_i && bus.pix_valid_i &&
                   (dx == '0) && (dy == '0);
    last_store_c = store_c && (wr_ptr == AW'(NPIX - 1));
    rd_next_c    = (rd_ptr == AW'(NPIX - 1)) ? '0 : rd_ptr + AW'(1);
    dx_next_c    = (dx == DW'(DEC - 1)) ? '0 : dx + DW'(1);
    dy_next_c    = (dy == DW'(DEC - 1)) ? '0 : dy + DW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (store_c) mem[wr_ptr] <= wdata_c;
  end

  // Control FSM, decimation counters and registered read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= ST_IDLE;
      sx                <= '0;
      dx                <= '0;
      dy                <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      bus.cam_pixel_o   <= '0;
      bus.frame_ready_o <= 1'b0;
      bus.busy_o        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (capture_c) begin
            state             <= ST_WAIT_FRAME;
            rd_ptr            <= '0;
            bus.cam_pixel_o   <= '0;
            bus.frame_ready_o <= 1'b0;
            bus.busy_o        <= 1'b1;
          end else if (read_c) begin
            rd_ptr          <= rd_next_c;
            bus.cam_pixel_o <= mem[rd_next_c];
          end
        end
        ST_WAIT_FRAME: begin
          if (bus.pix_frame_start_i) begin
            state  <= ST_CAPTURE;
            sx     <= '0;
            dx     <= '0;
            dy     <= '0;
            wr_ptr <= '0;
          end
        end
        ST_CAPTURE: begin
          if (bus.pix_frame_start_i) begin
            // New frame start mid-capture discards the partial frame
            sx     <= '0;
            dx     <= '0;
            dy     <= '0;
            wr_ptr <= '0;
          end else if (bus.pix_valid_i) begin
            dx <= dx_next_c;
            if (sx == XW'(SRC_W - 1)) begin
              sx <= '0;
              dy <= dy_next_c;
            end else begin
              sx <= sx + XW'(1);
            end
            if (store_c) wr_ptr <= last_store_c ? '0 : wr_ptr + AW'(1);
            if (last_store_c) begin
              state             <= ST_READY;
              bus.busy_o        <= 1'b0;
              bus.frame_ready_o <= 1'b1;
              bus.cam_pixel_o   <= (wr_ptr == '0) ? wdata_c : mem[0];
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cam_frame_buffer.sv
// Scoreboard bench for cam_frame_buffer on a reduced 8x6 image with 8x decimation.
module tb_cam_frame_buffer;
  localparam int IMG_W    = 8;
  localparam int IMG_H    = 6;
  localparam int DEC      = 8;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int SRC_W    = IMG_W * DEC;
  localparam int SRC_H    = IMG_H * DEC;
  localparam int SRC_N    = SRC_W * SRC_H;
  localparam int LAST_IDX = ((IMG_H - 1) * DEC) * SRC_W + (IMG_W - 1) * DEC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cam_frame_buffer_if bus();

  cam_frame_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DEC(DEC)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model [NPIX];
  int         tb_rd = 0;

  function automatic logic [7:0] stored(input logic [7:0] p);
`ifdef CAM_FRAME_BUFFER_INVERT_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic logic [7:0] src_pix(input int mode, input int sx, input int sy);
    case (mode)
      0:       return 8'(sx + sy);
      1:       return 8'h11;
      2:       return 8'h22;
      default: return 8'(3 * sx + sy);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives frame_start then npix source pixels with occasional idle gaps.
  task automatic send_frame(input int mode, input int npix, input bit push, input int cap_at,
                            output int ready_at);
    int widx;
    logic [7:0] p;
    ready_at = -1;
    widx = 0;
    bus.pix_frame_start_i = 1'b1;
    step();
    bus.pix_frame_start_i = 1'b0;
    for (int idx = 0; idx < npix; idx++) begin
      int sx;
      int sy;
      sx = idx % SRC_W;
      sy = idx / SRC_W;
      if ($urandom_range(7) == 0) begin
        bus.pix_valid_i = 1'b0;
        step();
      end
      p = src_pix(mode, sx, sy);
      bus.pix_data_i    = p;
      bus.pix_valid_i   = 1'b1;
      bus.cam_capture_i = (idx == cap_at);
      if (push && (sx % DEC == 0) && (sy % DEC == 0)) begin
        exp_q.push_back(stored(p));
        model[widx] = stored(p);
        widx++;
      end
      step();
      bus.cam_capture_i = 1'b0;
      bus.pix_valid_i   = 1'b0;
      if (ready_at < 0 && bus.frame_ready_o === 1'b1) ready_at = idx + 1;
    end
  endtask

  task automatic push_model(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(model[(tb_rd + k) % NPIX]);
  endtask

  // Pops one expected pixel per read; pixel is checked in the cycle the strobe is high.
  task automatic do_reads(input string name, input int n, input bit b2b);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: scoreboard empty, nothing expected", name, i);
      end else begin
        e = exp_q.pop_front();
        bus.cam_read_valid_i = 1'b1;
        if (bus.cam_pixel_o !== e) begin
          errors++;
          $display("FAIL %s[%0d]: cam_pixel_o=%02h expected %02h", name, i, bus.cam_pixel_o, e);
        end
        step();
        if (!b2b) begin
          bus.cam_read_valid_i = 1'b0;
          step();
        end
      end
    end
    bus.cam_read_valid_i = 1'b0;
    tb_rd = (tb_rd + n) % NPIX;
  endtask

  task automatic check_outs(input string name, input logic rdy, input logic bsy, input logic [7:0] pix);
    checks++;
    if (bus.frame_ready_o !== rdy || bus.busy_o !== bsy || bus.cam_pixel_o !== pix) begin
      errors++;
      $display("FAIL %s: ready/busy/pixel=%b/%b/%02h expected %b/%b/%02h", name,
               bus.frame_ready_o, bus.busy_o, bus.cam_pixel_o, rdy, bsy, pix);
    end
  endtask

  task automatic test_reset();
    int ra;
    step();
    step();
    check_outs("reset_values", 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    check_outs("after_reset_idle", 1'b0, 1'b0, 8'h00);
    bus.cam_capture_i = 1'b1;
    step();
    bus.cam_capture_i = 1'b0;
    check_outs("capture_latency", 1'b0, 1'b1, 8'h00);
    send_frame(0, 200, 1'b0, -1, ra);
    check_outs("mid_capture_busy", 1'b0, 1'b1, 8'h00);
    rst_n = 1'b0;
    #1;
    check_outs("async_reset_abort", 1'b0, 1'b0, 8'h00);
    step();
    check_outs("reset_held", 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    bus.cam_read_valid_i = 1'b1;
    step();
    bus.cam_read_valid_i = 1'b0;
    check_outs("idle_read_ignored", 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_capture();
    int ra;
    bus.cam_capture_i = 1'b1;
    step();
    bus.cam_capture_i = 1'b0;
    check_outs("wait_frame_entry", 1'b0, 1'b1, 8'h00);
    bus.cam_read_valid_i = 1'b1;
    #1;
    check_outs("wait_frame_read_pixel", 1'b0, 1'b1, 8'h00);
    step();
    bus.cam_read_valid_i = 1'b0;
    check_outs("wait_frame_read_ignored", 1'b0, 1'b1, 8'h00);
    tb_rd = 0;
    send_frame(0, SRC_N, 1'b1, 500, ra);
    checks++;
    if (ra !== LAST_IDX + 1) begin
      errors++;
      $display("FAIL ready_timing: ready after %0d pixels expected %0d", ra, LAST_IDX + 1);
    end
    check_outs("ready_state", 1'b1, 1'b0, model[0]);
    do_reads("readout", NPIX, 1'b0);
  endtask

  task automatic test_back_to_back();
    push_model(4);
    do_reads("wrap_b2b", 4, 1'b1);
  endtask

  task automatic test_truncated();
    int ra;
    bus.cam_capture_i = 1'b1;
    step();
    bus.cam_capture_i = 1'b0;
    check_outs("recapture_from_ready", 1'b0, 1'b1, 8'h00);
    send_frame(1, 1000, 1'b0, -1, ra);
    checks++;
    if (ra !== -1) begin
      errors++;
      $display("FAIL truncated_not_ready: ready after %0d pixels expected never", ra);
    end
    send_frame(2, SRC_N, 1'b1, -1, ra);
    checks++;
    if (ra !== LAST_IDX + 1) begin
      errors++;
      $display("FAIL truncated_ready_timing: ready after %0d pixels expected %0d", ra, LAST_IDX + 1);
    end
    tb_rd = 0;
    do_reads("truncated_readout", NPIX, 1'b0);
  endtask

  task automatic test_recapture();
    int ra;
    push_model(3);
    do_reads("pre_recapture", 3, 1'b0);
    bus.cam_capture_i    = 1'b1;
    bus.cam_read_valid_i = 1'b1;
    #1;
    check_outs("capture_read_same_cycle", 1'b1, 1'b0, model[3]);
    step();
    bus.cam_capture_i    = 1'b0;
    bus.cam_read_valid_i = 1'b0;
    check_outs("capture_wins", 1'b0, 1'b1, 8'h00);
    send_frame(3, SRC_N, 1'b1, -1, ra);
    checks++;
    if (ra !== LAST_IDX + 1) begin
      errors++;
      $display("FAIL recapture_ready_timing: ready after %0d pixels expected %0d", ra, LAST_IDX + 1);
    end
    tb_rd = 0;
    do_reads("recapture_readout", NPIX, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    bus.cam_capture_i     = 1'b0;
    bus.cam_read_valid_i  = 1'b0;
    bus.pix_frame_start_i = 1'b0;
    bus.pix_valid_i       = 1'b0;
    bus.pix_data_i        = 8'h00;
    test_reset();
    test_capture();
    test_back_to_back();
    test_truncated();
    test_recapture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
